// File: rtl/mlp_serial_core_if.sv
`default_nettype none
// ============================================================================
// Module      : mlp_serial_core_if
// Description : Bundle of the weight-write, input-vector and result
//               handshake signals of mlp_serial_core.
//               slave  modport : the core side
//               master modport : the driving side (feature buffer, host)
//   wr_en/wr_addr/wr_data -> weight register-file write port
//   wr_err                <- one-cycle pulse when a write is dropped
//   in_valid/in_x         -> input vector (x[i] = in_x[i*XW +: XW])
//   in_ready              <- core can take a vector
//   out_valid/out_y       <- result vector (y[k] = out_y[k*OW +: OW])
//   out_ready             -> downstream accepts the result
//   busy                  <- core is computing
// Revision    : 1.0 - initial release
// ============================================================================
interface mlp_serial_core_if #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int XW    = 5
);
    localparam int HW = 2 * XW + $clog2(N_IN);
    localparam int OW = HW + XW + $clog2(N_HID);
    localparam int NW = N_IN * N_HID + N_HID * N_OUT;
    localparam int AW = $clog2(NW);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XW-1:0]         wr_data;
    logic                  wr_err;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*XW-1:0]    in_x;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT*OW-1:0]   out_y;
    logic                  busy;

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_x, out_ready,
        output wr_err, in_ready, out_valid, out_y, busy
    );

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_x, out_ready,
        input  wr_err, in_ready, out_valid, out_y, busy
    );
endinterface
`default_nettype wire

// File: rtl/mlp_serial_core.sv
`default_nettype none
// ============================================================================
// Module      : mlp_serial_core
// Description : Time-multiplexed two-layer perceptron
//               N_IN -> N_HID (ReLU) -> N_OUT using a single shared MAC.
//               Weights sit in an internal writable register file:
//                 w1(i,j) at j*N_IN + i
//                 w2(j,k) at N_IN*N_HID + k*N_HID + j
//               Ports:
//                 clk   : rising-edge clock
//                 rst_n : asynchronous active-low reset
//                 bus   : mlp_serial_core_if.slave (write port, input and
//                         output valid/ready handshakes, busy, wr_err)
//               Optional macro MLP_OUT_SAT_EN: clamp each y[k] to a signed
//               OSAT_W range before sign-extending to OW bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_serial_core #(
    parameter int N_IN   = 4,
    parameter int N_HID  = 4,
    parameter int N_OUT  = 2,
    parameter int XW     = 5,
    parameter int OSAT_W = 16
) (
    input wire              clk,
    input wire              rst_n,
    mlp_serial_core_if.slave bus
);
    localparam int HW = 2 * XW + $clog2(N_IN);
    localparam int OW = HW + XW + $clog2(N_HID);
    localparam int NW = N_IN * N_HID + N_HID * N_OUT;
    localparam int AW = $clog2(NW);

    localparam int c_n_l1 = N_IN * N_HID;
    localparam int c_imax = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int c_iw   = (c_imax > 1) ? $clog2(c_imax) : 1;

    localparam logic signed [OW-1:0] c_sat_max =
        {{(OW-OSAT_W+1){1'b0}}, {(OSAT_W-1){1'b1}}};
    localparam logic signed [OW-1:0] c_sat_min =
        {{(OW-OSAT_W+1){1'b1}}, {(OSAT_W-1){1'b0}}};
`ifdef MLP_OUT_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    logic signed [XW-1:0]     r_w [NW];
    logic signed [XW-1:0]     r_x [N_IN];
    logic signed [HW-1:0]     r_h [N_HID];
    logic signed [OW-1:0]     r_y [N_OUT];
    logic signed [OW-1:0]     r_acc;
    logic [AW-1:0]            r_widx;
    logic [c_iw-1:0]          r_inner;
    logic                     r_out_valid;
    logic                     r_wr_err;

    logic                     w_busy;
    logic                     w_in_l1;
    logic signed [HW-1:0]     w_mul_a;
    logic signed [XW-1:0]     w_mul_b;
    logic signed [HW+XW-1:0]  w_prod;
    logic signed [OW-1:0]     w_acc_next;
    logic signed [HW-1:0]     w_relu;
    logic signed [OW-1:0]     w_y_next;
    logic                     w_inner_last;
    logic                     w_addr_ok;
    logic                     w_wr_ok;

    assign w_busy  = (r_state == S_L1) || (r_state == S_L2);
    assign w_in_l1 = (r_state == S_L1);

    // Both loops walk the weight file in address order, so one counter
    // addresses the weights. Operands are always taken from element 0 of
    // the x / h registers, which rotate one place per MAC cycle.
    assign w_mul_a    = w_in_l1 ? HW'(r_x[0]) : r_h[0];
    assign w_mul_b    = r_w[r_widx];
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_acc_next = r_acc + OW'(w_prod);

    // A layer-1 sum is bounded by HW bits, so only the sign needs checking.
    assign w_relu = w_acc_next[OW-1] ? '0 : w_acc_next[HW-1:0];

    assign w_inner_last = w_in_l1 ? (r_inner == c_iw'(N_IN - 1))
                                  : (r_inner == c_iw'(N_HID - 1));

    assign w_addr_ok = ({1'b0, bus.wr_addr} < (AW+1)'(NW));
    assign w_wr_ok   = bus.wr_en && w_addr_ok && !w_busy;

    always_comb begin
        w_y_next = w_acc_next;
        if (c_sat_en) begin
            if (w_acc_next > c_sat_max) begin
                w_y_next = c_sat_max;
            end else if (w_acc_next < c_sat_min) begin
                w_y_next = c_sat_min;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_widx      <= '0;
            r_inner     <= '0;
            r_out_valid <= 1'b0;
            r_wr_err    <= 1'b0;
            for (int n = 0; n < NW; n++)    r_w[n] <= '0;
            for (int n = 0; n < N_IN; n++)  r_x[n] <= '0;
            for (int n = 0; n < N_HID; n++) r_h[n] <= '0;
            for (int n = 0; n < N_OUT; n++) r_y[n] <= '0;
        end else begin
            r_wr_err <= bus.wr_en && (!w_addr_ok || w_busy);
            // Writes are independent of the state update below, so a write
            // coinciding with an accept or an output handshake still lands.
            if (w_wr_ok) begin
                r_w[bus.wr_addr] <= bus.wr_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N_IN; i++) begin
                            r_x[i] <= bus.in_x[i*XW +: XW];
                        end
                        r_acc   <= '0;
                        r_widx  <= '0;
                        r_inner <= '0;
                        r_state <= S_L1;
                    end
                end

                S_L1: begin
                    r_widx <= r_widx + AW'(1);
                    for (int i = 0; i < N_IN; i++) begin
                        r_x[i] <= r_x[(i + 1) % N_IN];
                    end
                    if (w_inner_last) begin
                        r_inner <= '0;
                        r_acc   <= '0;
                        // Hidden results shift in from the top so h[0]
                        // ends up in element 0 once the layer completes.
                        for (int n = 0; n < N_HID - 1; n++) begin
                            r_h[n] <= r_h[n + 1];
                        end
                        r_h[N_HID-1] <= w_relu;
                        if (r_widx == AW'(c_n_l1 - 1)) begin
                            r_state <= S_L2;
                        end
                    end else begin
                        r_inner <= r_inner + c_iw'(1);
                        r_acc   <= w_acc_next;
                    end
                end

                S_L2: begin
                    r_widx <= r_widx + AW'(1);
                    for (int n = 0; n < N_HID; n++) begin
                        r_h[n] <= r_h[(n + 1) % N_HID];
                    end
                    if (w_inner_last) begin
                        r_inner <= '0;
                        r_acc   <= '0;
                        for (int n = 0; n < N_OUT - 1; n++) begin
                            r_y[n] <= r_y[n + 1];
                        end
                        r_y[N_OUT-1] <= w_y_next;
                        if (r_widx == AW'(NW - 1)) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_inner <= r_inner + c_iw'(1);
                        r_acc   <= w_acc_next;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.wr_err    = r_wr_err;

    for (genvar k = 0; k < N_OUT; k++) begin : g_pack
        assign bus.out_y[k*OW +: OW] = r_y[k];
    end
endmodule
`default_nettype wire
